// File: rtl/mem_types_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
// Store/load type codes and the bus FSM state type.
package mem_types_pkg;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_dbus_master_if.sv
// Data bus between the LSU (master) and data memory (slave).
// Request side is registered in the master.
interface lsu_dbus_master_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [31:0]       wdata;
  logic              err;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;

  modport master (
    output req, wr, addr, wstrb, wdata, err,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, addr, wstrb, wdata, err,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/lsu_dbus_master_align.sv
// Byte-lane logic: store strobes/replication, alignment checks,
// and load lane extraction with sign/zero extension.
module lsu_align
  import mem_types_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_src,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  rd_off,
  input  logic [2:0]  rd_type,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        st_mis,
  output logic        st_rsv,
  output logic        ld_mis,
  output logic        ld_rsv,
  output logic [31:0] ld_data
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{rd_off, 3'b000} +: 8];
  assign h = rd_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wstrb  = 4'b0000;
    wdata  = 32'h0;
    st_mis = 1'b0;
    st_rsv = 1'b0;
    unique case (1'b1)
      (st_type == ST_SW): begin
        wstrb  = 4'b1111;
        wdata  = st_src;
        st_mis = (st_off != 2'b00);
      end
      (st_type == ST_SH): begin
        wstrb  = st_off[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{st_src[15:0]}};
        st_mis = st_off[0];
      end
      (st_type == ST_SB): begin
        wstrb  = 4'b0001 << st_off;
        wdata  = {4{st_src[7:0]}};
      end
      default: st_rsv = 1'b1;
    endcase
  end

  always_comb begin
    ld_mis = 1'b0;
    ld_rsv = 1'b0;
    unique case (1'b1)
      (ld_type == LD_LW): ld_mis = (ld_off != 2'b00);
      (ld_type == LD_LH),
      (ld_type == LD_LHU): ld_mis = ld_off[0];
      (ld_type == LD_LB),
      (ld_type == LD_LBU): ld_mis = 1'b0;
      default: ld_rsv = 1'b1;
    endcase
  end

  always_comb begin
    ld_data = 32'h0;
    unique case (1'b1)
      (rd_type == LD_LW):  ld_data = rdata;
      (rd_type == LD_LH):  ld_data = {{16{h[15]}}, h};
      (rd_type == LD_LHU): ld_data = {16'h0, h};
      (rd_type == LD_LB):  ld_data = {{24{b[7]}}, b};
      (rd_type == LD_LBU): ld_data = {24'h0, b};
      default:             ld_data = 32'h0;
    endcase
  end
endmodule

// File: rtl/lsu_dbus_master.sv
// MEM-stage load/store initiator: one handshaked data-bus
// request per access, pipeline stall until completion.
module lsu_dbus_master
  import mem_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_ALUOut_i,
  input  logic [31:0] MEM_OutB_i,
  input  logic        MEM_DMWr_i,
  input  logic        MEM_DMRd_i,
  input  logic [1:0]  MEM_StoreType_i,
  input  logic [2:0]  MEM_LoadType_i,
  input  logic        MEM_Flush_i,
  output logic [31:0] MEM_DMOut_o,
  output logic        MEM_Stall_o,
  output logic        MEM_AdEL_o,
  output logic        MEM_AdES_o,
  lsu_dbus_master_if.master dbus
);
  localparam int CNT_W =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  lsu_state_e        state;
  logic              req_q, wr_q, err_q, cancel;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        strb_q;
  logic [31:0]       wdata_q, dmout_q;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        q_type;
  logic [1:0]        q_off;

  logic [3:0]  strb_n;
  logic [31:0] wdata_n, ld_data;
  logic        st_mis, st_rsv, ld_mis, ld_rsv;
  logic        wr_sel, rd_sel, acc_valid, to_hit, keep;

  lsu_align u_align (
    .st_off  (MEM_ALUOut_i[1:0]),
    .st_type (MEM_StoreType_i),
    .st_src  (MEM_OutB_i),
    .ld_off  (MEM_ALUOut_i[1:0]),
    .ld_type (MEM_LoadType_i),
    .rd_off  (q_off),
    .rd_type (q_type),
    .rdata   (dbus.rdata),
    .wstrb   (strb_n),
    .wdata   (wdata_n),
    .st_mis  (st_mis),
    .st_rsv  (st_rsv),
    .ld_mis  (ld_mis),
    .ld_rsv  (ld_rsv),
    .ld_data (ld_data)
  );

  assign wr_sel = MEM_DMWr_i;
  assign rd_sel = MEM_DMRd_i & ~MEM_DMWr_i;
  assign acc_valid = ~MEM_Flush_i &
    ((wr_sel & ~st_mis & ~st_rsv) |
     (rd_sel & ~ld_mis & ~ld_rsv));

  assign MEM_AdES_o  = wr_sel & st_mis;
  assign MEM_AdEL_o  = rd_sel & ld_mis;
  assign MEM_Stall_o = ((state == S_IDLE) & acc_valid) |
                       (state == S_REQ) | (state == S_WAIT);
  assign MEM_DMOut_o = dmout_q;

  // Cancelled or store transactions never deliver data.
  assign keep   = ~wr_q & ~cancel & ~MEM_Flush_i;
  assign to_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

  assign dbus.req   = req_q;
  assign dbus.wr    = wr_q;
  assign dbus.addr  = addr_q;
  assign dbus.wstrb = strb_q;
  assign dbus.wdata = wdata_q;
  assign dbus.err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cancel  <= 1'b0;
      addr_q  <= '0;
      strb_q  <= 4'h0;
      wdata_q <= 32'h0;
      dmout_q <= 32'h0;
      cnt     <= '0;
      q_type  <= LD_LW;
      q_off   <= 2'b00;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (acc_valid) begin
            state   <= S_REQ;
            req_q   <= 1'b1;
            wr_q    <= wr_sel;
            addr_q  <= {MEM_ALUOut_i[ADDR_W-1:2], 2'b00};
            strb_q  <= wr_sel ? strb_n : 4'h0;
            wdata_q <= wr_sel ? wdata_n : 32'h0;
            dmout_q <= 32'h0;
            cancel  <= 1'b0;
            q_type  <= MEM_LoadType_i;
            q_off   <= MEM_ALUOut_i[1:0];
          end
        end
        S_REQ: begin
          if (MEM_Flush_i) cancel <= 1'b1;
          if (dbus.addr_ok) begin
            req_q <= 1'b0;
            if (dbus.data_ok) begin
              state   <= S_DONE;
              dmout_q <= keep ? ld_data : 32'h0;
            end else begin
              state <= S_WAIT;
              cnt   <= '0;
            end
          end
        end
        S_WAIT: begin
          if (MEM_Flush_i) cancel <= 1'b1;
          if (dbus.data_ok) begin
            state   <= S_DONE;
            dmout_q <= keep ? ld_data : 32'h0;
          end else if (to_hit) begin
            state   <= S_DONE;
            dmout_q <= 32'h0;
            err_q   <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          cancel <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_dbus_master.sv
// Directed bench for lsu_dbus_master: vector table plus
// flush, timeout and reset sequences.
module tb_lsu_dbus_master;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, outb;
  logic        dmwr, dmrd, flush;
  logic [1:0]  st_type;
  logic [2:0]  ld_type;
  logic [31:0] dmout;
  logic        stall, adel, ades;

  int checks = 0;
  int passes = 0;

  lsu_dbus_master_if #(.ADDR_W(32)) bus ();

  lsu_dbus_master #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .MEM_ALUOut_i    (alu),
    .MEM_OutB_i      (outb),
    .MEM_DMWr_i      (dmwr),
    .MEM_DMRd_i      (dmrd),
    .MEM_StoreType_i (st_type),
    .MEM_LoadType_i  (ld_type),
    .MEM_Flush_i     (flush),
    .MEM_DMOut_o     (dmout),
    .MEM_Stall_o     (stall),
    .MEM_AdEL_o      (adel),
    .MEM_AdES_o      (ades),
    .dbus            (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  st;
    logic [2:0]  ld;
    logic [31:0] addr;
    logic [31:0] b;
    logic [31:0] rdata;
    logic        acc;
    logic        adel;
    logic        ades;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] dmout;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dmwr = 1'b0; dmrd = 1'b0; flush = 1'b0;
    alu = 32'h0; outb = 32'h0;
    st_type = 2'b00; ld_type = 3'b000;
    bus.addr_ok = 1'b0; bus.data_ok = 1'b0;
    bus.rdata = 32'h0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   nst;
    v = vecs[i];
    alu = v.addr; outb = v.b;
    dmwr = v.wr; dmrd = v.rd;
    st_type = v.st; ld_type = v.ld;
    bus.rdata = v.rdata;
    #1;
    chk($sformatf("v%0d adel", i), 32'(adel), 32'(v.adel));
    chk($sformatf("v%0d ades", i), 32'(ades), 32'(v.ades));
    if (!v.acc) begin
      chk($sformatf("v%0d nostall", i), 32'(stall), 32'd0);
      tick();
      chk($sformatf("v%0d noreq", i), 32'(bus.req), 32'd0);
      idle_inputs();
      tick();
      return;
    end
    nst = int'(stall);
    tick();
    chk($sformatf("v%0d req", i), 32'(bus.req), 32'd1);
    chk($sformatf("v%0d wr", i), 32'(bus.wr), 32'(v.wr));
    chk($sformatf("v%0d addr", i), bus.addr,
        {v.addr[31:2], 2'b00});
    chk($sformatf("v%0d wstrb", i), 32'(bus.wstrb), 32'(v.strb));
    if (v.wr)
      chk($sformatf("v%0d wdata", i), bus.wdata, v.wdata);
    nst += int'(stall);
    bus.addr_ok = 1'b1;
    bus.data_ok = 1'b1;
    tick();
    chk($sformatf("v%0d done_stall", i), 32'(stall), 32'd0);
    chk($sformatf("v%0d done_req", i), 32'(bus.req), 32'd0);
    chk($sformatf("v%0d dmout", i), dmout, v.dmout);
    chk($sformatf("v%0d stall_cyc", i), 32'(nst), 32'd2);
    idle_inputs();
    tick();
  endtask

  initial begin
    //        wr   rd   st     ld      addr      b             rdata         acc adel ades strb  wdata         dmout
    vecs[0]  = '{1'b1,1'b0,2'b00,3'b000,32'h104,32'hDEADBEEF,32'h0,       1'b1,1'b0,1'b0,4'hF,32'hDEADBEEF,32'h0};
    vecs[1]  = '{1'b1,1'b0,2'b10,3'b000,32'h107,32'h000000A5,32'h0,       1'b1,1'b0,1'b0,4'h8,32'hA5A5A5A5,32'h0};
    vecs[2]  = '{1'b1,1'b0,2'b01,3'b000,32'h102,32'h1234ABCD,32'h0,       1'b1,1'b0,1'b0,4'hC,32'hABCDABCD,32'h0};
    vecs[3]  = '{1'b1,1'b0,2'b10,3'b000,32'h100,32'h7777773C,32'h0,       1'b1,1'b0,1'b0,4'h1,32'h3C3C3C3C,32'h0};
    vecs[4]  = '{1'b1,1'b0,2'b01,3'b000,32'h100,32'h00005A69,32'h0,       1'b1,1'b0,1'b0,4'h3,32'h5A695A69,32'h0};
    vecs[5]  = '{1'b0,1'b1,2'b00,3'b011,32'h103,32'h0,       32'h80FF0011,1'b1,1'b0,1'b0,4'h0,32'h0,       32'hFFFFFF80};
    vecs[6]  = '{1'b0,1'b1,2'b00,3'b100,32'h103,32'h0,       32'h80FF0011,1'b1,1'b0,1'b0,4'h0,32'h0,       32'h00000080};
    vecs[7]  = '{1'b0,1'b1,2'b00,3'b001,32'h102,32'h0,       32'h80FF0011,1'b1,1'b0,1'b0,4'h0,32'h0,       32'hFFFF80FF};
    vecs[8]  = '{1'b0,1'b1,2'b00,3'b010,32'h100,32'h0,       32'h80FF8011,1'b1,1'b0,1'b0,4'h0,32'h0,       32'h00008011};
    vecs[9]  = '{1'b0,1'b1,2'b00,3'b000,32'h108,32'h0,       32'h80FF0011,1'b1,1'b0,1'b0,4'h0,32'h0,       32'h80FF0011};
    vecs[10] = '{1'b0,1'b1,2'b00,3'b011,32'h101,32'h0,       32'h12345678,1'b1,1'b0,1'b0,4'h0,32'h0,       32'h00000056};
    vecs[11] = '{1'b0,1'b1,2'b00,3'b000,32'h101,32'h0,       32'h0,       1'b0,1'b1,1'b0,4'h0,32'h0,       32'h0};
    vecs[12] = '{1'b1,1'b0,2'b01,3'b000,32'h003,32'h0,       32'h0,       1'b0,1'b0,1'b1,4'h0,32'h0,       32'h0};
    vecs[13] = '{1'b1,1'b0,2'b11,3'b000,32'h100,32'h0,       32'h0,       1'b0,1'b0,1'b0,4'h0,32'h0,       32'h0};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst req", 32'(bus.req), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst dmout", dmout, 32'h0);
    chk("rst err", 32'(bus.err), 32'd0);
    chk("rst wstrb", 32'(bus.wstrb), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(i);

    // Flush while REQ waits for addr_ok
    alu = 32'h200; dmrd = 1'b1; ld_type = 3'b000;
    #1;
    chk("fl stall0", 32'(stall), 32'd1);
    tick();
    flush = 1'b1;
    dmrd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      flush = 1'b0;
      chk($sformatf("fl req%0d", k), 32'(bus.req), 32'd1);
      chk($sformatf("fl stall%0d", k + 1), 32'(stall), 32'd1);
    end
    bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0;
    chk("fl wait req", 32'(bus.req), 32'd0);
    chk("fl wait stall", 32'(stall), 32'd1);
    tick();
    chk("fl hold stall", 32'(stall), 32'd1);
    bus.data_ok = 1'b1;
    bus.rdata = 32'hCAFEBABE;
    tick();
    chk("fl dmout", dmout, 32'h0);
    chk("fl done stall", 32'(stall), 32'd0);
    idle_inputs();
    tick();

    // Timeout with data_ok never arriving
    alu = 32'h300; dmrd = 1'b1; ld_type = 3'b000;
    bus.rdata = 32'h11111111;
    tick();
    bus.addr_ok = 1'b1;
    dmrd = 1'b0;
    tick();
    bus.addr_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to stall%0d", k), 32'(stall), 32'd1);
      chk($sformatf("to err%0d", k), 32'(bus.err), 32'd0);
      tick();
    end
    chk("to done err", 32'(bus.err), 32'd1);
    chk("to done stall", 32'(stall), 32'd0);
    chk("to dmout", dmout, 32'h0);
    tick();
    chk("to err pulse", 32'(bus.err), 32'd0);

    // Reset in WAIT and in REQ
    alu = 32'h400; dmrd = 1'b1;
    tick();
    bus.addr_ok = 1'b1;
    dmrd = 1'b0;
    tick();
    bus.addr_ok = 1'b0;
    chk("rw in wait", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw stall", 32'(stall), 32'd0);
    chk("rw req", 32'(bus.req), 32'd0);
    alu = 32'h404; dmrd = 1'b1;
    tick();
    chk("rr req", 32'(bus.req), 32'd1);
    dmrd = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr req drop", 32'(bus.req), 32'd0);
    chk("rr stall", 32'(stall), 32'd0);
    tick();
    run_vec(0);
    run_vec(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
